// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD display types, limits and nibble helper
package bcd_disp_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef logic [3:0] nibble_t;
  function automatic nibble_t get_nibble(input logic [31:0] v, input int i);
    return v[i*4 +: 4];
  endfunction
endpackage

// File: rtl/bcd_refresh_timer.sv
// bcd_refresh_timer: slot prescaler, slot index and frame-boundary strobe for scan blocks
module bcd_refresh_timer #(
  parameter int DIV = 50000,
  parameter int N = 4,
  localparam int CW = $clog2(DIV),
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] o_cnt,
  output logic [IW-1:0] o_idx,
  output logic          o_frame
);
  logic w_wrap;
  assign w_wrap = o_cnt == CW'(DIV - 1);
  assign o_frame = w_wrap && o_idx == IW'(N - 1);
  // prescaler counts a slot; index advances (mod N) as each slot ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
      o_idx <= '0;
    end else if (w_wrap) begin
      o_cnt <= '0;
      o_idx <= o_frame ? '0 : o_idx + 1'b1;
    end else begin
      o_cnt <= o_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: tear-free multiplexed BCD digit scanner with dead-time and leading-zero blanking
module bcd_digit_scanner
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD = 2,
  localparam int CW = $clog2(REFRESH_DIV),
  localparam int IW = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  lzb_en,
  output logic                  err,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an_n
);
  logic [4*DIGITS-1:0] r_shadow, r_pending;
  logic                r_pend;
  logic [CW-1:0]       w_cnt;
  logic [IW-1:0]       w_idx;
  logic                w_frame, w_xfer, w_bad, w_zero, w_lit;
  logic [DIGITS-1:0]   w_blank, w_sel;

  bcd_refresh_timer #(.DIV(REFRESH_DIV), .N(DIGITS)) u_timer (
    .clk(clk), .rst_n(rst_n), .o_cnt(w_cnt), .o_idx(w_idx), .o_frame(w_frame)
  );

  assign din_ready = !r_pend;
  assign w_xfer = din_valid && !r_pend;
  assign w_sel = DIGITS'(1) << w_idx;
  assign w_lit = w_cnt >= CW'(DEAD) && !w_blank[w_idx];

  // reject offers containing any non-BCD nibble
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) w_bad = w_bad | (get_nibble(32'(din), i) > BCD_MAX);
  end

  // a digit is blanked when it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    w_blank = '0;
    w_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero = w_zero && get_nibble(32'(r_shadow), i) == 4'd0;
      w_blank[i] = lzb_en && w_zero;
    end
  end

  // accept into pending, promote to shadow only at a frame boundary, register display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_pending <= '0;
      r_pend <= 1'b0;
      err <= 1'b0;
      bcd <= 4'd0;
      an_n <= '1;
    end else begin
      err <= w_xfer && w_bad;
      if (w_xfer && !w_bad) begin
        r_pending <= din;
        r_pend <= 1'b1;
      end else if (w_frame && r_pend) begin
        r_shadow <= r_pending;
        r_pend <= 1'b0;
      end
      bcd <= get_nibble(32'(r_shadow), int'(w_idx));
      an_n <= w_lit ? ~w_sel : '1;
    end
  end
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb_bcd_digit_scanner: randomized and directed checks against a cycle-level reference model
module tb_bcd_digit_scanner;
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, lzb_en = 1'b0;
  logic [15:0] din = '0;
  logic din_ready, err;
  logic [3:0] bcd, an_n;
  int n_chk = 0, n_err = 0;
  int t = 0;
  logic [15:0] m_shadow = '0, m_pending = '0;
  bit m_pend = 0;
  logic [3:0] e_bcd = 4'd0, e_an = 4'hF;
  logic e_err = 1'b0;

  bcd_digit_scanner #(.DIGITS(4), .REFRESH_DIV(8), .DEAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .lzb_en(lzb_en), .err(err), .bcd(bcd), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd", 16'(bcd), 16'(e_bcd));
    chk("an_n", 16'(an_n), 16'(e_an));
    chk("err", 16'(err), 16'(e_err));
    chk("din_ready", 16'(din_ready), 16'(!m_pend));
  endtask

  task automatic model_reset();
    t = 0; m_shadow = '0; m_pending = '0; m_pend = 0;
    e_bcd = 4'd0; e_an = 4'hF; e_err = 1'b0;
  endtask

  task automatic step();
    int slot, d;
    bit bad, xfer, lit;
    slot = t % 8;
    d = (t / 8) % 4;
    bad = 0;
    for (int k = 0; k < 4; k++) if (((din >> (4 * k)) & 16'hF) > 9) bad = 1;
    xfer = din_valid && !m_pend;
    lit = slot >= 2 && !(lzb_en && d > 0 && (m_shadow >> (4 * d)) == 0);
    e_bcd = 4'((m_shadow >> (4 * d)) & 16'hF);
    e_an = lit ? 4'((~(1 << d)) & 4'hF) : 4'hF;
    e_err = xfer && bad;
    if (xfer && !bad) begin
      m_pending = din; m_pend = 1;
    end else if (slot == 7 && d == 3 && m_pend) begin
      m_shadow = m_pending; m_pend = 0;
    end
    @(posedge clk);
    t++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input logic [15:0] v);
    din = v; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    run(32);
    lzb_en = 1'b1;
    run(32);
    lzb_en = 1'b0;
    run(11);
    offer(16'h1234);
    run(40);
    offer(16'h12A4);
    offer(16'hF000);
    run(16);
    lzb_en = 1'b1;
    offer(16'h0070);
    run(40);
    lzb_en = 1'b0;
    run(32);
    while (t % 32 != 31) step();
    offer(16'h5555);
    din = 16'h9999; din_valid = 1'b1;
    run(80);
    din_valid = 1'b0;
    run(8);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      din = v;
      din_valid = $urandom_range(0, 3) == 0;
      lzb_en = 1'($urandom_range(0, 1));
      step();
    end
    din_valid = 1'b0;
    lzb_en = 1'b0;
    run(13);
    offer(16'h8642);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    run(70);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
